// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded instruction fields back into 32-bit words
//   (cond[31:28] op[27:26] funct[25:20] Rn[19:16] Rd[15:12] src2[11:0])
//   and streams them into instruction memory, one word per clock, while
//   holding the processor off via cpu_hold.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a checksum[31:0] output carries the XOR of every word
//     written in the current session.
//
//   Timing: a bundle accepted on edge N appears on imem_we/imem_addr/
//   imem_wdata during the cycle after edge N. imem_addr and count advance
//   on the edge that closes that write cycle. A reset arriving while a
//   write is pending suppresses the strobe immediately.
module instr_encoder_loader #(
  parameter int         ADDR_WIDTH = 6,
  parameter int         DEPTH      = 64,
  parameter int         START_ADDR = 0,
  parameter logic [3:0] COND_DEF   = 4'hE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [5:0]            in_funct,
  input  logic [3:0]            in_rn,
  input  logic [3:0]            in_rd,
  input  logic [11:0]           in_src2,
  input  logic [23:0]           in_imm24,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0]            OP_BR    = 2'b10;
  localparam logic [1:0]            OP_ILL   = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] START_A  = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(START_ADDR + DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  // Branch words keep only the top two funct bits above the 24-bit offset;
  // every other legal op carries the full register/operand layout.
  function automatic logic [31:0] pack_word(
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    logic [31:0] word;
    if (op == OP_BR) begin
      word = {COND_DEF, OP_BR, funct[5:4], imm24};
    end else begin
      word = {COND_DEF, op, funct, rn, rd, src2};
    end
    return word;
  endfunction

  state_t                r_state;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_err;
  logic                  r_we_p1;
  logic [31:0]           r_wdata_p1;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_hs;
  logic                  w_illegal;
  logic                  w_accept_word;
  logic                  w_restart;
  logic [ADDR_WIDTH:0]   w_accepted;
  logic                  w_full;
  logic [31:0]           w_word;

  // in_ready is only ever high in LOAD, so a handshake implies LOAD.
  assign w_hs          = in_valid & r_in_ready;
  assign w_illegal     = (in_op == OP_ILL);
  assign w_accept_word = w_hs & ~w_illegal;
  // start is honoured from IDLE, DONE and ERR; it is ignored mid-session.
  assign w_restart     = start & (r_state != S_LOAD);
  // Words accepted before this one: those already written plus the one in flight.
  assign w_accepted    = r_count + {{ADDR_WIDTH{1'b0}}, r_we_p1};
  assign w_full        = (w_accepted == LAST_CNT);
  assign w_word        = pack_word(in_op, in_funct, in_rn, in_rd, in_src2, in_imm24);

  // Session FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_hs) begin
            if (w_illegal) begin
              // An illegal op aborts even when it is also flagged last.
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end else if (in_last) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if (w_full) begin
              // Capacity reached without a last marker: word is still written.
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR all leave only on start.
          if (start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
      endcase
    end
  end

  // Write stage: capture the packed word and raise the strobe for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we_p1    <= 1'b0;
      r_wdata_p1 <= 32'd0;
    end else begin
      r_we_p1 <= w_accept_word;
      if (w_accept_word) begin
        r_wdata_p1 <= w_word;
      end
    end
  end

  // Address and word counter advance once each write cycle completes.
  always_ff @(posedge clk) begin
    if (reset || w_restart) begin
      r_addr  <= START_A;
      r_count <= '0;
    end else if (r_we_p1) begin
      r_count <= r_count + 1'b1;
      // Hold at the top of the window so the address never wraps.
      if (r_addr != LAST_A) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running XOR; folds each word in on the same edge that raises its strobe.
  always_ff @(posedge clk) begin
    if (reset || w_restart) begin
      r_checksum <= 32'd0;
    end else if (w_accept_word) begin
      r_checksum <= r_checksum ^ w_word;
    end
  end

  assign checksum = r_checksum;
`endif

  // A reset landing on a pending write drops it without waiting an edge.
  assign imem_we    = r_we_p1 & ~reset;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata_p1;
  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: directed table, hand sequences for
// multi-cycle corners, and randomized sessions checked against a
// behavioural model. A second instance with DEPTH=4 covers overflow.
module tb_instr_encoder_loader;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_last;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [3:0]  in_rn, in_rd;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;

  logic          d_ready, d_we, d_hold, d_busy, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [AW:0]   d_count;
  logic          s_ready, s_we, s_hold, s_busy, s_done, s_err;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [AW:0]   s_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   d_cs, s_cs;
`endif

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(64), .START_ADDR(0), .COND_DEF(4'hE)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(d_ready),
    .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .in_last(in_last), .imem_we(d_we), .imem_addr(d_addr),
    .imem_wdata(d_wdata), .cpu_hold(d_hold), .busy(d_busy), .done(d_done), .err(d_err),
`ifdef LOADER_CHECKSUM_EN
    .checksum(d_cs),
`endif
    .count(d_count));

  instr_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(4), .START_ADDR(0), .COND_DEF(4'hE)) u_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_ready),
    .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .in_last(in_last), .imem_we(s_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .cpu_hold(s_hold), .busy(s_busy), .done(s_done), .err(s_err),
`ifdef LOADER_CHECKSUM_EN
    .checksum(s_cs),
`endif
    .count(s_count));

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic        last;
  } bund_t;

  typedef struct {
    bund_t       b;
    logic [31:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] dq_addr[$], dq_data[$], sq_addr[$], sq_data[$];
  int          dq_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors: record every strobe seen on each instance.
  always @(negedge clk) begin
    if (d_we === 1'b1) begin
      dq_addr.push_back(32'(d_addr));
      dq_data.push_back(d_wdata);
      dq_cyc.push_back(cyc);
    end
    if (s_we === 1'b1) begin
      sq_addr.push_back(32'(s_addr));
      sq_data.push_back(s_wdata);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    dq_addr.delete(); dq_data.delete(); dq_cyc.delete();
    sq_addr.delete(); sq_data.delete();
  endtask

  task automatic drive(input bund_t b, input logic v);
    in_valid = v;   in_op = b.op;     in_funct = b.funct; in_rn = b.rn;
    in_rd = b.rd;   in_src2 = b.src2; in_imm24 = b.imm24; in_last = b.last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; idle_in();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Reference packing from the word-format definition, using arithmetic.
  function automatic logic [31:0] model_word(input bund_t b);
    int unsigned w;
    w = 32'hE000_0000;
    if (b.op == 2'd2) begin
      w = w + (32'd2 << 26) + ((32'(b.funct) / 16) << 24) + 32'(b.imm24);
    end else begin
      w = w + (32'(b.op) << 26) + (32'(b.funct) << 20) + (32'(b.rn) << 16)
            + (32'(b.rd) << 12) + 32'(b.src2);
    end
    return w;
  endfunction

  function automatic bund_t mk(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rn,
                               input logic [3:0] rd, input logic [11:0] s2, input logic [23:0] im,
                               input logic last);
    bund_t b;
    b.op = op; b.funct = f; b.rn = rn; b.rd = rd; b.src2 = s2; b.imm24 = im; b.last = last;
    return b;
  endfunction

  // One-bundle session with last=1; checks the write cycle and final status.
  task automatic run_single(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    pulse_start();
    drive(v.b, 1'b1);
    tick();
    idle_in();
    check({t, "_we"},    32'(d_we), 32'd1);
    check({t, "_addr"},  32'(d_addr), 32'd0);
    check({t, "_wdata"}, d_wdata, v.exp);
    check({t, "_done"},  32'(d_done), 32'd1);
    check({t, "_hold"},  32'(d_hold), 32'd0);
    tick();
    check({t, "_count"}, 32'(d_count), 32'd1);
  endtask

  task automatic run_random(input int idx);
    bund_t       s[$];
    bund_t       b;
    logic [31:0] ea[$], ew[$];
    logic [31:0] csum;
    int          kind, len, nacc;
    logic        edone, eerr;
    string       t;
    t = $sformatf("rnd%0d", idx);
    kind = $urandom_range(0, 7);
    len  = (kind == 0) ? 66 : $urandom_range(1, 12);
    for (int i = 0; i < len; i++) begin
      b.op    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      b.funct = 6'($urandom); b.rn = 4'($urandom); b.rd = 4'($urandom);
      b.src2  = 12'($urandom); b.imm24 = 24'($urandom);
      b.last  = (kind != 0) && (i == len - 1);
      s.push_back(b);
    end
    // Model: accept in order until illegal op, last, or capacity.
    edone = 1'b0; eerr = 1'b0; nacc = 0; csum = 32'd0;
    foreach (s[i]) begin
      if (s[i].op == 2'd3) begin eerr = 1'b1; break; end
      ea.push_back(32'(nacc));
      ew.push_back(model_word(s[i]));
      csum = csum ^ model_word(s[i]);
      nacc++;
      if (s[i].last) begin edone = 1'b1; break; end
      if (nacc == 64) begin eerr = 1'b1; break; end
    end
    clear_q();
    pulse_start();
    foreach (s[i]) begin
      while ($urandom_range(0, 3) == 0) begin
        idle_in();
        tick();
      end
      drive(s[i], 1'b1);
      tick();
    end
    idle_in();
    tick(); tick();
    check({t, "_nwr"}, 32'(dq_data.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < dq_data.size(); i++) begin
      check($sformatf("%s_addr%0d", t, i), dq_addr[i], ea[i]);
      check($sformatf("%s_word%0d", t, i), dq_data[i], ew[i]);
    end
    check({t, "_done"},  32'(d_done), 32'(edone));
    check({t, "_err"},   32'(d_err), 32'(eerr));
    check({t, "_hold"},  32'(d_hold), 32'(!edone));
    check({t, "_count"}, 32'(d_count), 32'(ew.size()));
    check({t, "_ready"}, 32'(d_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check({t, "_csum"},  d_cs, csum);
`endif
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{mk(2'b00, 6'b001001, 4'h1, 4'h2, 12'h003, 24'hABCDEF, 1'b1), 32'hE0912003};
    tbl[1] = '{mk(2'b10, 6'b110000, 4'h7, 4'h8, 12'h555, 24'hFFFFFE, 1'b1), 32'hEBFFFFFE};
    tbl[2] = '{mk(2'b01, 6'b011001, 4'h3, 4'h4, 12'h010, 24'h123456, 1'b1), 32'hE5934010};
    tbl[3] = '{mk(2'b10, 6'b010101, 4'hF, 4'hF, 12'hFFF, 24'h000010, 1'b1), 32'hE9000010};
    tbl[4] = '{mk(2'b00, 6'h3F,     4'hF, 4'hF, 12'hFFF, 24'h000000, 1'b1), 32'hE3FFFFFF};

    reset = 1'b1; start = 1'b0;
    drive(mk(2'b00, 6'd0, 4'd0, 4'd0, 12'd0, 24'd0, 1'b0), 1'b0);
    do_reset();

    // Reset state.
    check("rst_ready", 32'(d_ready), 32'd0);
    check("rst_busy",  32'(d_busy),  32'd0);
    check("rst_done",  32'(d_done),  32'd0);
    check("rst_err",   32'(d_err),   32'd0);
    check("rst_hold",  32'(d_hold),  32'd1);
    check("rst_we",    32'(d_we),    32'd0);
    check("rst_addr",  32'(d_addr),  32'd0);
    check("rst_count", 32'(d_count), 32'd0);
    check("rst_wdata", d_wdata,      32'd0);

    // Table-driven single-word sessions.
    for (int i = 0; i < 5; i++) run_single(i, tbl[i]);

    // Back-to-back bundles; a start pulse mid-session must be ignored.
    clear_q();
    pulse_start();
    check("b2b_busy", 32'(d_busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(mk(2'b00, 6'(k + 1), 4'(k), 4'(k + 5), 12'(k * 17), 24'd0, k == 2), 1'b1);
      start = (k == 1);
      tick();
    end
    start = 1'b0; idle_in();
    tick();
    check("b2b_nwr", 32'(dq_data.size()), 32'd3);
    for (int k = 0; k < 3 && k < dq_data.size(); k++) begin
      check($sformatf("b2b_addr%0d", k), dq_addr[k], 32'(k));
      check($sformatf("b2b_word%0d", k), dq_data[k],
            model_word(mk(2'b00, 6'(k + 1), 4'(k), 4'(k + 5), 12'(k * 17), 24'd0, k == 2)));
      if (k > 0) check($sformatf("b2b_gap%0d", k), 32'(dq_cyc[k] - dq_cyc[k-1]), 32'd1);
    end
    check("b2b_count", 32'(d_count), 32'd3);
    check("b2b_done",  32'(d_done),  32'd1);

    // Illegal op on the second bundle, also flagged last.
    clear_q();
    pulse_start();
    drive(mk(2'b00, 6'd9, 4'd1, 4'd2, 12'd3, 24'd0, 1'b0), 1'b1); tick();
    drive(mk(2'b11, 6'd9, 4'd1, 4'd2, 12'd3, 24'd0, 1'b1), 1'b1); tick();
    idle_in(); tick();
    check("ill_nwr",   32'(dq_data.size()), 32'd1);
    check("ill_err",   32'(d_err),   32'd1);
    check("ill_done",  32'(d_done),  32'd0);
    check("ill_hold",  32'(d_hold),  32'd1);
    check("ill_ready", 32'(d_ready), 32'd0);
    check("ill_count", 32'(d_count), 32'd1);

    // Overflow on the DEPTH=4 instance: five bundles, none last.
    clear_q();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      drive(mk(2'b01, 6'd2, 4'(k), 4'd0, 12'(k), 24'd0, 1'b0), 1'b1);
      tick();
    end
    idle_in(); tick(); tick();
    check("ovf_nwr", 32'(sq_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < sq_data.size(); k++) begin
      check($sformatf("ovf_addr%0d", k), sq_addr[k], 32'(k));
      check($sformatf("ovf_word%0d", k), sq_data[k],
            model_word(mk(2'b01, 6'd2, 4'(k), 4'd0, 12'(k), 24'd0, 1'b0)));
    end
    check("ovf_err",   32'(s_err),   32'd1);
    check("ovf_hold",  32'(s_hold),  32'd1);
    check("ovf_count", 32'(s_count), 32'd4);
    check("ovf_addr_hold", 32'(s_addr), 32'd3);

    // Reset the cycle after a handshake drops the pending write.
    do_reset();
    clear_q();
    pulse_start();
    drive(mk(2'b00, 6'd1, 4'd1, 4'd1, 12'd1, 24'd0, 1'b0), 1'b1);
    tick();
    idle_in();
    reset = 1'b1;
    #1;
    check("rmid_we", 32'(d_we), 32'd0);
    tick();
    reset = 1'b0;
    check("rmid_busy",  32'(d_busy),  32'd0);
    check("rmid_ready", 32'(d_ready), 32'd0);
    check("rmid_hold",  32'(d_hold),  32'd1);
    check("rmid_count", 32'(d_count), 32'd0);
    tick();
    check("rmid_nwr", 32'(dq_data.size()), 32'd0);

    // Randomized sessions against the model.
    for (int i = 0; i < 40; i++) run_random(i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
